// File: rtl/next_pc_predict_pkg.sv
// Shared definitions for the next-PC predictor: branch codes, counter states
// and small helpers used by both the resolver and the predictor arrays.
package next_pc_predict_pkg;

  localparam logic [2:0] BR_SEQ  = 3'd0;
  localparam logic [2:0] BR_JAL  = 3'd1;
  localparam logic [2:0] BR_JALR = 3'd2;
  localparam logic [2:0] BR_EQ   = 3'd4;
  localparam logic [2:0] BR_NE   = 3'd5;
  localparam logic [2:0] BR_LT   = 3'd6;
  localparam logic [2:0] BR_GE   = 3'd7;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_t;

  function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != CTR_ST) n = ctr_t'(c + 2'd1);
    end else begin
      if (c != CTR_SNT) n = ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

  // Codes 4..7 are the compare-based conditionals.
  function automatic logic is_cond(input logic [2:0] code);
    return code[2];
  endfunction

  function automatic logic is_uncond(input logic [2:0] code);
    return (code == BR_JAL) || (code == BR_JALR);
  endfunction

endpackage

// File: rtl/next_pc_predict_branch_resolve.sv
// Purely combinational resolution of a control instruction on the ex_* bus:
// actual direction and actual (halfword-aligned) target.
module branch_resolve
  import next_pc_predict_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      ex_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_zero,
  input  logic            ex_less,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  always_comb begin
    taken = 1'b0;
    case (ex_branch)
      BR_SEQ:          taken = 1'b0;
      BR_JAL, BR_JALR: taken = 1'b1;
      BR_EQ:           taken = ex_zero;
      BR_NE:           taken = ~ex_zero;
      BR_LT:           taken = ex_less;
      BR_GE:           taken = ~ex_less;
      default:         taken = 1'b0;
    endcase
  end

  // Only jalr is register-relative; everything else is pc-relative.
  always_comb begin
    base   = (ex_branch == BR_JALR) ? ex_rs1 : ex_pc;
    sum    = ex_imm + base;
    target = {sum[XLEN-1:1], 1'b0};
  end

endmodule

// File: rtl/next_pc_predict.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit BHT; redirects and
// flushes on a resolved mispredict from the execute stage.
module next_pc_predict
  import next_pc_predict_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter int              BHT_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [2:0]      ex_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_zero,
  input  logic            ex_less,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pc_valid_q;

  logic             btb_valid_q  [BHT_DEPTH];
  logic             btb_valid_d  [BHT_DEPTH];
  logic             btb_uncond_q [BHT_DEPTH];
  logic             btb_uncond_d [BHT_DEPTH];
  logic [TAG_W-1:0] btb_tag_q    [BHT_DEPTH];
  logic [TAG_W-1:0] btb_tag_d    [BHT_DEPTH];
  logic [XLEN-1:0]  btb_tgt_q    [BHT_DEPTH];
  logic [XLEN-1:0]  btb_tgt_d    [BHT_DEPTH];
  ctr_t             ctr_q        [BHT_DEPTH];
  ctr_t             ctr_d        [BHT_DEPTH];

  logic [IDX_W-1:0] fe_idx, ex_idx;
  logic [TAG_W-1:0] fe_tag, ex_tag;
  logic             ex_taken;
  logic [XLEN-1:0]  ex_target;
  logic             ex_hit;
  logic             mispredict;

  branch_resolve #(.XLEN(XLEN)) u_resolve (
    .ex_branch (ex_branch),
    .ex_pc     (ex_pc),
    .ex_imm    (ex_imm),
    .ex_rs1    (ex_rs1),
    .ex_zero   (ex_zero),
    .ex_less   (ex_less),
    .taken     (ex_taken),
    .target    (ex_target)
  );

  assign fe_idx = pc_q[IDX_W+1:2];
  assign fe_tag = pc_q[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

  // Lookup reads only registered state, so a same-cycle update is not seen.
  assign pred_taken  = btb_valid_q[fe_idx] && (btb_tag_q[fe_idx] == fe_tag) &&
                       (btb_uncond_q[fe_idx] ||
                        (ctr_q[fe_idx] == CTR_WT) || (ctr_q[fe_idx] == CTR_ST));
  assign pred_target = btb_tgt_q[fe_idx];

  assign ex_hit     = btb_valid_q[ex_idx] && (btb_tag_q[ex_idx] == ex_tag);
  assign mispredict = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));

  // Reset also masks a mispredict that is still on the ex bus.
  assign flush    = mispredict & ~rst;
  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;

  always_comb begin
    pc_d = pc_q;
    if (mispredict) begin
      pc_d = ex_taken ? ex_target : (ex_pc + XLEN'(4));
    end else if (if_ready && pc_valid_q) begin
      pc_d = pred_taken ? pred_target : (pc_q + XLEN'(4));
    end
  end

  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_uncond_d = btb_uncond_q;
    btb_tag_d    = btb_tag_q;
    btb_tgt_d    = btb_tgt_q;
    ctr_d        = ctr_q;
    if (ex_valid) begin
      if (is_cond(ex_branch)) begin
        ctr_d[ex_idx] = ctr_update(ctr_q[ex_idx], ex_taken);
      end
      if (ex_taken) begin
        btb_valid_d[ex_idx]  = 1'b1;
        btb_uncond_d[ex_idx] = is_uncond(ex_branch);
        btb_tag_d[ex_idx]    = ex_tag;
        btb_tgt_d[ex_idx]    = ex_target;
        // A freshly allocated conditional starts weakly taken.
        if (is_cond(ex_branch) && !ex_hit) begin
          ctr_d[ex_idx] = CTR_WT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        btb_valid_q[i] <= 1'b0;
        ctr_q[i]       <= CTR_WNT;
      end
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        btb_valid_q[i] <= btb_valid_d[i];
        ctr_q[i]       <= ctr_d[i];
      end
    end
  end

  // Payload fields are qualified by the valid bit and need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BHT_DEPTH; i++) begin
      btb_uncond_q[i] <= btb_uncond_d[i];
      btb_tag_q[i]    <= btb_tag_d[i];
      btb_tgt_q[i]    <= btb_tgt_d[i];
    end
  end

endmodule

// File: tb/tb_next_pc_predict.sv
// Directed bench for next_pc_predict: reset, jal/jalr allocation, counter
// training, redirect priority, PC wrap and mid-operation reset.
module tb_next_pc_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready;
  logic [63:0] pc;
  logic        pc_valid;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid;
  logic [2:0]  ex_branch;
  logic [63:0] ex_pc, ex_imm, ex_rs1;
  logic        ex_zero, ex_less;
  logic        ex_pred_taken;
  logic [63:0] ex_pred_target;
  logic        flush;

  int checks = 0;
  int errors = 0;

  next_pc_predict dut (
    .clk            (clk),
    .rst            (rst),
    .if_ready       (if_ready),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .ex_zero        (ex_zero),
    .ex_less        (ex_less),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [2:0] code, input logic [63:0] epc,
                          input logic [63:0] imm, input logic [63:0] rs1,
                          input logic zero, input logic pt, input logic [63:0] ptgt);
    ex_valid       = 1'b1;
    ex_branch      = code;
    ex_pc          = epc;
    ex_imm         = imm;
    ex_rs1         = rs1;
    ex_zero        = zero;
    ex_less        = 1'b0;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic clear_ex();
    ex_valid      = 1'b0;
    ex_branch     = 3'd0;
    ex_pred_taken = 1'b0;
  endtask

  // A sequential op wrongly predicted taken redirects to a-4+4 = a without
  // touching predictor state.
  task automatic redirect(input logic [63:0] a);
    drive_ex(3'd0, a - 64'd4, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0);
    tick();
    clear_ex();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_ready = 1'b1; clear_ex();
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_zero = 1'b0; ex_less = 1'b0;
    ex_pred_target = '0;
    #1 rst = 1'b1;
    #2;
    checks++; if (pc !== 64'h8000_0000) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, 64'h8000_0000); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_pc_valid: got %b want 0", pc_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", flush); end
    tick(); tick();
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b want 0", pc_valid); end
    rst = 1'b0;
    tick();
    checks++; if (pc !== 64'h8000_0000 || pc_valid !== 1'b1) begin errors++; $display("FAIL rel_pc0: got %h/%b want 80000000/1", pc, pc_valid); end
    tick();
    checks++; if (pc !== 64'h8000_0004) begin errors++; $display("FAIL rel_pc1: got %h want 80000004", pc); end
    checks++; if (pred_taken !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rel_pred: got %b/%b want 0/0", pred_taken, flush); end
    tick();
    checks++; if (pc !== 64'h8000_0008) begin errors++; $display("FAIL rel_pc2: got %h want 80000008", pc); end
    if_ready = 1'b0;
  endtask

  task automatic test_jal();
    drive_ex(3'd1, 64'h8000_0010, 64'h20, 64'd0, 1'b0, 1'b0, 64'd0);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jal_flush: got %b want 1", flush); end
    tick();
    checks++; if (pc !== 64'h8000_0030) begin errors++; $display("FAIL jal_pc: got %h want 80000030", pc); end
    clear_ex(); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jal_flush_pulse: got %b want 0", flush); end
    redirect(64'h8000_0010);
    checks++; if (pc !== 64'h8000_0010) begin errors++; $display("FAIL jal_redir: got %h want 80000010", pc); end
    checks++; if (pred_taken !== 1'b1 || pred_target !== 64'h8000_0030) begin errors++; $display("FAIL jal_pred: got %b/%h want 1/80000030", pred_taken, pred_target); end
    if_ready = 1'b1;
    tick();
    checks++; if (pc !== 64'h8000_0030) begin errors++; $display("FAIL jal_follow: got %h want 80000030", pc); end
    if_ready = 1'b0;
  endtask

  task automatic test_jalr();
    drive_ex(3'd2, 64'h8000_0040, 64'd0, 64'h8000_1001, 1'b0, 1'b0, 64'd0);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jalr_flush: got %b want 1", flush); end
    tick();
    checks++; if (pc !== 64'h8000_1000) begin errors++; $display("FAIL jalr_pc: got %h want 80001000", pc); end
    clear_ex(); #1;
    redirect(64'h8000_0040);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 64'h8000_1000) begin errors++; $display("FAIL jalr_pred: got %b/%h want 1/80001000", pred_taken, pred_target); end
  endtask

  task automatic test_counter();
    redirect(64'h8000_0108);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cnt_cold: got %b want 0", pred_taken); end
    drive_ex(3'd4, 64'h8000_0108, 64'h40, 64'd0, 1'b1, 1'b0, 64'd0);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL cnt_t1_flush: got %b want 1", flush); end
    tick();
    checks++; if (pc !== 64'h8000_0148) begin errors++; $display("FAIL cnt_t1_pc: got %h want 80000148", pc); end
    checks++; if (dut.ctr_q[2] !== 2'd2) begin errors++; $display("FAIL cnt_t1_ctr: got %0d want 2", dut.ctr_q[2]); end
    drive_ex(3'd4, 64'h8000_0108, 64'h40, 64'd0, 1'b1, 1'b1, 64'h8000_0148);
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL cnt_t2_flush: got %b want 0", flush); end
    tick();
    checks++; if (dut.ctr_q[2] !== 2'd3) begin errors++; $display("FAIL cnt_t2_ctr: got %0d want 3", dut.ctr_q[2]); end
    tick();
    checks++; if (dut.ctr_q[2] !== 2'd3) begin errors++; $display("FAIL cnt_t3_ctr: got %0d want 3", dut.ctr_q[2]); end
    checks++; if (pc !== 64'h8000_0148) begin errors++; $display("FAIL cnt_hold_pc: got %h want 80000148", pc); end
    drive_ex(3'd4, 64'h8000_0108, 64'h40, 64'd0, 1'b0, 1'b1, 64'h8000_0148);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL cnt_nt_flush: got %b want 1", flush); end
    tick();
    checks++; if (pc !== 64'h8000_010C) begin errors++; $display("FAIL cnt_nt_pc: got %h want 8000010c", pc); end
    checks++; if (dut.ctr_q[2] !== 2'd2) begin errors++; $display("FAIL cnt_nt_ctr: got %0d want 2", dut.ctr_q[2]); end
    clear_ex(); #1;
    redirect(64'h8000_0108);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 64'h8000_0148) begin errors++; $display("FAIL cnt_pred: got %b/%h want 1/80000148", pred_taken, pred_target); end
  endtask

  task automatic test_back_to_back();
    if_ready = 1'b1;
    drive_ex(3'd4, 64'h8000_0108, 64'h40, 64'd0, 1'b0, 1'b1, 64'h8000_0148);
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL b2b_pre_pred: got %b want 1", pred_taken); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush: got %b want 1", flush); end
    tick();
    clear_ex(); if_ready = 1'b0; #1;
    checks++; if (pc !== 64'h8000_010C) begin errors++; $display("FAIL b2b_pc: got %h want 8000010c", pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse: got %b want 0", flush); end
    redirect(64'h8000_0108);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL b2b_post_pred: got %b want 0", pred_taken); end
  endtask

  task automatic test_wrap();
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h want fffffffffffffffc", pc); end
    if_ready = 1'b1;
    tick();
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", pc); end
    tick();
    checks++; if (pc !== 64'h4) begin errors++; $display("FAIL wrap_four: got %h want 4", pc); end
    if_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_ex(3'd1, 64'h8000_0200, 64'h100, 64'd0, 1'b0, 1'b0, 64'd0);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL midrst_pre_flush: got %b want 1", flush); end
    rst = 1'b1;
    #1;
    checks++; if (pc !== 64'h8000_0000 || flush !== 1'b0 || pc_valid !== 1'b0) begin errors++; $display("FAIL midrst_now: got %h/%b/%b want 80000000/0/0", pc, flush, pc_valid); end
    tick();
    checks++; if (pc !== 64'h8000_0000) begin errors++; $display("FAIL midrst_hold: got %h want 80000000", pc); end
    clear_ex(); rst = 1'b0;
    tick();
    redirect(64'h8000_0010);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_jal_pred: got %b want 0", pred_taken); end
    redirect(64'h8000_0108);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_cond_pred: got %b want 0", pred_taken); end
    redirect(64'h8000_0040);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_jalr_pred: got %b want 0", pred_taken); end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_jalr();
    test_counter();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/next_pc_predict.md
NEXT_PC_PREDICT -- requirements
Module: next_pc_predict

Interface
REQ-001 Parameter XLEN, default 64, datapath and PC width.
REQ-002 Parameter BHT_DEPTH, default 16, number of 2-bit counters and BTB entries; power of 2, at least 2.
REQ-003 Parameter RESET_PC, default 64'h8000_0000, PC loaded on reset.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 if_ready  in  1  fetch accepts the current PC this cycle.
REQ-007 pc  out  XLEN  current fetch PC.
REQ-008 pc_valid  out  1  pc is presentable to fetch.
REQ-009 pred_taken  out  1  prediction for pc.
REQ-010 pred_target  out  XLEN  predicted target for pc, valid only when pred_taken=1.
REQ-011 ex_valid  in  1  a resolved control instruction is on the ex_* bus.
REQ-012 ex_branch  in  3  code: 0 seq, 1 pc+imm (jal), 2 rs1+imm (jalr), 4 eq, 5 ne, 6 lt, 7 ge; 3 is treated as 0.
REQ-013 ex_pc, ex_imm, ex_rs1  in  XLEN each  resolved PC, immediate, and rs1 value.
REQ-014 ex_zero, ex_less  in  1 each  ALU compare flags.
REQ-015 ex_pred_taken, ex_pred_target  in  1/XLEN  prediction carried down the pipe with ex_pc.
REQ-016 flush  out  1  one-cycle pulse that kills younger instructions.

Function
REQ-017 Index: idx = pc[log2(BHT_DEPTH)+1:2]; tag = pc[XLEN-1:log2(BHT_DEPTH)+2].
REQ-018 Each BHT counter SHALL be a 2-bit saturating state: SNT=0, WNT=1, WT=2, ST=3. Taken increments to a ceiling of 3; not-taken decrements to a floor of 0.
REQ-019 pred_taken SHALL be combinational: BTB[idx] valid, tag match, and (entry is unconditional, or counter is WT or ST).
REQ-020 Actual taken: codes 1 and 2 always; code 4 when ex_zero; 5 when !ex_zero; 6 when ex_less; 7 when !ex_less; codes 0 and 3 never.
REQ-021 Actual target: (ex_imm + (code==2 ? ex_rs1 : ex_pc)) with bit 0 forced to 0. Addition is modulo 2^XLEN.
REQ-022 Mispredict = ex_valid and (taken != ex_pred_taken, or taken and target != ex_pred_target).
REQ-023 On mispredict: next pc = taken ? target : ex_pc+4; flush=1 for exactly that cycle; if_ready is ignored in that cycle.
REQ-024 Otherwise, when if_ready and pc_valid: next pc = pred_taken ? pred_target : pc+4. Otherwise pc holds.
REQ-025 On ex_valid with a conditional code (4 to 7): counter[ex idx] is updated by the actual outcome.
REQ-026 On ex_valid with taken=1: write the BTB entry {valid, tag, target, uncond=(code 1 or 2)}. A taken conditional that allocates a new tag SHALL set its counter to WT.
REQ-027 A same-cycle update and lookup to the same idx SHALL return the pre-update value to the lookup; the update is visible on the next cycle.
REQ-028 PC wrap past 2^XLEN-4 SHALL be modulo; no error is raised.
REQ-029 pc_valid SHALL be 0 while rst is asserted and 1 from the first clock edge after release.

Reset
REQ-030 Asynchronous reset SHALL set pc=RESET_PC, pc_valid=0, flush=0, all counters to WNT, and all BTB valid bits to 0.
REQ-031 Reset mid-operation SHALL discard any pending redirect and all predictor state.

Structure
REQ-032 A shared package SHALL hold the branch code constants (BR_SEQ, BR_JAL, BR_JALR, BR_EQ, BR_NE, BR_LT, BR_GE) and the counter state typedef.
REQ-033 One sub-module, branch_resolve, SHALL be purely combinational and compute taken/target from the ex_* bus. Arrays and the PC register live in the top module.

Verification
REQ-034 Reset release with if_ready=1 and no ex_valid -> pc goes 0x80000000, 0x80000004, 0x80000008; pred_taken=0; flush=0.
REQ-035 ex_valid, code 1, ex_pc=0x80000010, imm=0x20, pred_taken=0 -> flush=1 for one cycle, next pc=0x80000030; a later fetch of 0x80000010 gives pred_taken=1 and pred_target=0x80000030.
REQ-036 Code 2, rs1=0x80001001, imm=0 -> target 0x80001000 (bit 0 cleared).
REQ-037 Code 4 at the same PC resolved taken 3 times, then not-taken once -> counter goes WT, ST, ST, WT and the prediction stays taken; the not-taken resolution flushes and sets next pc=ex_pc+4.
REQ-038 Mispredict in the same cycle as if_ready=1 with pred_taken=1 -> the redirect wins and exactly one flush pulse is produced.
REQ-039 Assert rst while a mispredict is pending -> pc=0x80000000 immediately, flush=0, and all predictions are not-taken afterwards.
